// File: rtl/uart_packet_rx.sv
// UART packet receiver: oversampled 8N1 bytes assembled into a wide packet word,
// handed to the command decoder through a one-deep valid/ready holding register.
module uart_packet_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PACKET_BYTES = 16,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX,
   output logic [PACKET_BYTES*8-1:0] PKT_DATA,
   output logic                      PKT_VALID,
   input  logic                      PKT_READY,
   output logic                      FRAME_ERR,
   output logic                      TIMEOUT_ERR,
   output logic                      OVERRUN,
   output logic                      BUSY
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int GW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
   localparam int CW = $clog2(PACKET_BYTES + 1);
   localparam int PW = PACKET_BYTES * 8;

   localparam logic [BW-1:0] BIT_HALF  = BW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BYTE_LAST = CW'(PACKET_BYTES - 1);

   typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state;
   logic            rx_p0;
   logic            rxs;
   logic [BW-1:0]   bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [CW-1:0]   byte_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [PW-1:0]   asm_q;
   logic [PW-1:0]   asm_next;

   // Synchroniser stage: rx_p0 -> rxs
   always_ff @(posedge CLK) begin
      rx_p0 <= RX;
      rxs   <= rx_p0;
   end

   // Assembly word with the byte just received dropped into its slot, so a
   // completing packet can be handed over on the same edge as its last stop bit.
   always_comb begin
      asm_next = asm_q;
      for (int k = 0; k < PACKET_BYTES; k++) begin
         if (byte_cnt == CW'(k)) asm_next[8*k +: 8] = shift;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= ARM;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         byte_cnt    <= '0;
         gap_cnt     <= '0;
         PKT_DATA    <= '0;
         PKT_VALID   <= 1'b0;
         FRAME_ERR   <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         OVERRUN     <= 1'b0;
      end else begin
         FRAME_ERR   <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         OVERRUN     <= 1'b0;
         if (PKT_VALID && PKT_READY) PKT_VALID <= 1'b0;

         case (state)
            ARM: if (rxs) state <= IDLE;
            IDLE: begin
               if (!rxs) begin
                  state   <= START;
                  bit_cnt <= '0;
                  gap_cnt <= '0;
               end else if (byte_cnt != '0) begin
                  if (gap_cnt == GAP_LAST) begin
                     byte_cnt    <= '0;
                     gap_cnt     <= '0;
                     TIMEOUT_ERR <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
            end
            START: begin
               if (bit_cnt == BIT_HALF) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     bit_idx <= '0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shift   <= {rxs, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     asm_q <= asm_next;
                     if (byte_cnt == BYTE_LAST) begin
                        byte_cnt <= '0;
                        // A free slot or a same-cycle handshake takes the packet.
                        if (!PKT_VALID || PKT_READY) begin
                           PKT_DATA  <= asm_next;
                           PKT_VALID <= 1'b1;
                        end else begin
                           OVERRUN <= 1'b1;
                        end
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                     end
                  end else begin
                     FRAME_ERR <= 1'b1;
                     byte_cnt  <= '0;
                     state     <= BREAK;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            BREAK: if (rxs) state <= IDLE;
            default: state <= ARM;
         endcase
      end
   end

   assign BUSY = (state != ARM && state != IDLE && state != BREAK) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: a 16-byte receiver at 32 clocks/bit and a
// 2-byte receiver at 16 clocks/bit, checked against hand-computed packets.
module tb_uart_packet_rx;

   localparam int CPB  = 32;
   localparam int CPB2 = 16;

   logic         CLK = 1'b0;
   logic         RST;
   logic         RX, RX2;
   logic         PKT_READY, PKT_READY2;
   logic [127:0] PKT_DATA;
   logic [15:0]  PKT_DATA2;
   logic         PKT_VALID, PKT_VALID2;
   logic         FRAME_ERR, TIMEOUT_ERR, OVERRUN, BUSY;
   logic         FRAME_ERR2, TIMEOUT_ERR2, OVERRUN2, BUSY2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_cnt = 0, hs2_cnt = 0, fe_cnt = 0, to_cnt = 0, ovr_cnt = 0;
   int to_cyc = 0;
   logic [127:0] cap;
   logic [15:0]  cap2;

   uart_packet_rx #(.CLKS_PER_BIT(CPB), .PACKET_BYTES(16), .TIMEOUT_BITS(20)) dut (
      .CLK(CLK), .RST(RST), .RX(RX), .PKT_DATA(PKT_DATA), .PKT_VALID(PKT_VALID),
      .PKT_READY(PKT_READY), .FRAME_ERR(FRAME_ERR), .TIMEOUT_ERR(TIMEOUT_ERR),
      .OVERRUN(OVERRUN), .BUSY(BUSY));

   uart_packet_rx #(.CLKS_PER_BIT(CPB2), .PACKET_BYTES(2), .TIMEOUT_BITS(20)) dut2 (
      .CLK(CLK), .RST(RST), .RX(RX2), .PKT_DATA(PKT_DATA2), .PKT_VALID(PKT_VALID2),
      .PKT_READY(PKT_READY2), .FRAME_ERR(FRAME_ERR2), .TIMEOUT_ERR(TIMEOUT_ERR2),
      .OVERRUN(OVERRUN2), .BUSY(BUSY2));

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      #1;
      if (PKT_VALID && PKT_READY) begin
         hs_cnt++;
         cap = PKT_DATA;
      end
      if (PKT_VALID2 && PKT_READY2) begin
         hs2_cnt++;
         cap2 = PKT_DATA2;
      end
      if (FRAME_ERR) fe_cnt++;
      if (OVERRUN) ovr_cnt++;
      if (TIMEOUT_ERR) begin
         to_cnt++;
         to_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) RX2 = v;
      else     RX  = v;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input int per, input logic stop_bit);
      set_line(sel, 1'b0);
      idle(per);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, b[i]);
         idle(per);
      end
      set_line(sel, stop_bit);
      idle(per);
      set_line(sel, 1'b1);
   endtask

   task automatic send_pkt(input logic [127:0] p, input int per);
      for (int k = 0; k < 16; k++) send_byte(1'b0, p[8*k +: 8], per, 1'b1);
   endtask

   localparam logic [127:0] PA = 128'h0F0E0D0C0B0A09080706050403020103;
   localparam logic [127:0] PB = 128'h1F1E1D1C1B1A19181716151413121110;
   localparam logic [127:0] PC = 128'h8F8E8D8C8B8A89888786858483828180;
   localparam logic [127:0] PD = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] PE = 128'hDEADBEEFCAFEF00D5A5AA5A500FF7E81;
   localparam logic [127:0] PF = 128'h55AA55AA33CC33CC0F0FF0F012345678;
   localparam logic [127:0] PG = 128'hC3C33C3C9669699681818118E7E77E7E;

   initial begin
      int h0;
      int t_end;
      RST = 1'b0; RX = 1'b1; RX2 = 1'b1; PKT_READY = 1'b0; PKT_READY2 = 1'b1;
      idle(10);
      check("rst_valid", PKT_VALID, 0);
      check("rst_data", PKT_DATA, 0);
      check("rst_busy", BUSY, 0);
      check("rst_pulses", {FRAME_ERR, TIMEOUT_ERR, OVERRUN}, 0);
      RST = 1'b1;
      idle(8);

      // Packet with consumer ready
      PKT_READY = 1'b1;
      send_pkt(PA, CPB);
      idle(2 * CPB);
      check("pa_hs", hs_cnt, 1);
      check("pa_data", cap, PA);
      check("pa_byte0", cap[7:0], 8'h03);
      check("pa_byte15", cap[127:120], 8'h0F);
      check("pa_valid_clr", PKT_VALID, 0);
      check("pa_busy", BUSY, 0);

      // Held packet at a slightly fast bit rate, then overrun
      PKT_READY = 1'b0;
      send_pkt(PB, CPB - 1);
      idle(2 * CPB);
      check("pb_valid", PKT_VALID, 1);
      check("pb_data", PKT_DATA, PB);
      send_pkt(PC, CPB);
      idle(2 * CPB);
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_data", PKT_DATA, PB);
      check("ovr_valid", PKT_VALID, 1);
      PKT_READY = 1'b1;
      idle(1);
      check("pb_release", PKT_VALID, 0);
      check("pb_hs", hs_cnt, 2);
      check("pb_cap", cap, PB);

      // Framing error on the fifth byte
      h0 = hs_cnt;
      for (int k = 0; k < 4; k++) send_byte(1'b0, 8'h40 + 8'(k), CPB, 1'b1);
      send_byte(1'b0, 8'h55, CPB, 1'b0);
      idle(2 * CPB);
      check("fe_cnt", fe_cnt, 1);
      check("fe_no_pkt", hs_cnt, h0);
      check("fe_busy", BUSY, 0);
      send_pkt(PD, CPB);
      idle(2 * CPB);
      check("pd_hs", hs_cnt, h0 + 1);
      check("pd_data", cap, PD);

      // Partial packet abandoned after the gap timeout
      for (int k = 0; k < 7; k++) send_byte(1'b0, 8'hE0 + 8'(k), CPB, 1'b1);
      t_end = cyc;
      check("to_busy_partial", BUSY, 1);
      idle(25 * CPB);
      check("to_cnt", to_cnt, 1);
      check("to_latency", (to_cyc - t_end >= 624) && (to_cyc - t_end <= 632), 1);
      check("to_busy", BUSY, 0);

      // Short glitch on an idle line
      RX = 1'b0;
      idle(2);
      RX = 1'b1;
      idle(CPB);
      check("glitch_busy", BUSY, 0);
      check("glitch_fe", fe_cnt, 1);
      send_pkt(PE, CPB);
      idle(2 * CPB);
      check("pe_hs", hs_cnt, h0 + 2);
      check("pe_data", cap, PE);

      // Reset in the middle of byte 3 with a packet held
      PKT_READY = 1'b0;
      send_pkt(PF, CPB);
      idle(2 * CPB);
      check("pf_valid", PKT_VALID, 1);
      send_byte(1'b0, 8'h11, CPB, 1'b1);
      send_byte(1'b0, 8'h22, CPB, 1'b1);
      RX = 1'b0;
      idle(CPB + CPB / 2);
      RST = 1'b0;
      idle(1);
      RST = 1'b1;
      check("mrst_valid", PKT_VALID, 0);
      check("mrst_data", PKT_DATA, 0);
      check("mrst_busy", BUSY, 0);
      idle(3 * CPB);
      check("arm_busy", BUSY, 0);
      check("arm_fe", fe_cnt, 1);
      RX = 1'b1;
      idle(8);
      PKT_READY = 1'b1;
      send_pkt(PG, CPB);
      idle(2 * CPB);
      check("pg_hs", hs_cnt, h0 + 3);
      check("pg_data", cap, PG);
      check("to_total", to_cnt, 1);

      // Two-byte receiver
      send_byte(1'b1, 8'hA5, CPB2, 1'b1);
      send_byte(1'b1, 8'h3C, CPB2, 1'b1);
      idle(2 * CPB2);
      check("small_hs", hs2_cnt, 1);
      check("small_data", cap2, 16'h3CA5);
      check("small_busy", BUSY2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
